// File: rtl/sim_pkg.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : sim_pkg
// Purpose  : Shared defaults and types for the simulation clock/reset source.
// Revision : 1.0
// ============================================================================
package sim_pkg;

  localparam int c_half_period  = 1;
  localparam int c_reset_cycles = 2;
  localparam int c_cycle_w      = 32;

  typedef logic [c_cycle_w-1:0] cycle_t;

endpackage : sim_pkg
`default_nettype wire

// File: rtl/reset_sync_gen.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : reset_sync_gen
// Purpose  : Power-on reset held for RESET_CYCLES rising edges, released on
//            the following falling edge.
// Revision : 1.0
// ============================================================================
module reset_sync_gen
  import sim_pkg::*;
#(
  parameter int RESET_CYCLES = c_reset_cycles
) (
  input  logic clock,
  output logic reset
);

  localparam logic [31:0] c_hold = 32'(RESET_CYCLES);

  logic [31:0] r_count   = '0;
  logic        r_release = 1'b0;
  logic        r_reset   = (RESET_CYCLES > 0);

  // Count rising edges seen with reset high; arm the release on the last one.
  always_ff @(posedge clock) begin
    if (r_reset && !r_release) begin
      r_count <= r_count + 32'd1;
      if (r_count + 32'd1 >= c_hold)
        r_release <= 1'b1;
    end
  end

  // Dropping reset mid-period gives sampling flops a clean synchronous release.
  always_ff @(negedge clock) begin
    if (r_release)
      r_reset <= 1'b0;
  end

  assign reset = r_reset;

endmodule : reset_sync_gen
`default_nettype wire

// File: rtl/clock_gen.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : clock_gen
// Purpose  : Simulation clock, reset and cycle counter source with watchdog.
// Revision : 1.0
// ============================================================================
module clock_gen
  import sim_pkg::*;
#(
  parameter int HALF_PERIOD  = c_half_period,
  parameter int RESET_CYCLES = c_reset_cycles,
  parameter int CYCLE_W      = c_cycle_w,
  parameter int MAX_CYCLES   = 0
) (
  output logic               clock,
  output logic               reset,
  output logic [CYCLE_W-1:0] cycle,
  output logic               running
);

  localparam logic               c_wd_en = (MAX_CYCLES != 0);
  localparam logic [CYCLE_W-1:0] c_max   = CYCLE_W'(MAX_CYCLES);

  logic               r_clock   = 1'b1;
  logic [CYCLE_W-1:0] r_cycle   = '0;
  logic               r_running = 1'b1;
  logic [CYCLE_W-1:0] w_cycle_nxt;

  // Blocking update so a sampler resuming at an edge time sees the new level.
  always begin
    #(HALF_PERIOD) r_clock = ~r_clock;
  end

  reset_sync_gen #(
    .RESET_CYCLES (RESET_CYCLES)
  ) u_reset (
    .clock (r_clock),
    .reset (reset)
  );

  assign w_cycle_nxt = r_cycle + CYCLE_W'(1);

  always_ff @(posedge r_clock) begin
    if (reset)
      r_cycle <= '0;
    else
      r_cycle <= w_cycle_nxt;
  end

  always_ff @(posedge r_clock) begin
    if (c_wd_en && !reset && r_running && (w_cycle_nxt == c_max)) begin
      r_running <= 1'b0;
      $display("clock_gen: watchdog expired at cycle %0d", w_cycle_nxt);
      $finish;
    end
  end

  assign clock   = r_clock;
  assign cycle   = r_cycle;
  assign running = r_running;

endmodule : clock_gen
`default_nettype wire

// File: tb/tb_clock_gen.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : tb_clock_gen
// Purpose  : Randomly timed sampling of several clock_gen configurations.
// Revision : 1.0
// ============================================================================
module tb_clock_gen;
  import sim_pkg::*;

  int n_checks = 0;
  int n_fail   = 0;

  logic       d_clk, d_rst, d_run;
  cycle_t     d_cyc;
  logic       h_clk, h_rst, h_run;
  cycle_t     h_cyc;
  logic       z_clk, z_rst, z_run;
  cycle_t     z_cyc;
  logic       n_clk, n_rst, n_run;
  logic [1:0] n_cyc;
  logic       w_clk, w_rst, w_run;
  cycle_t     w_cyc;

  localparam int c_wd_max = 60;

  clock_gen u_def (
    .clock (d_clk), .reset (d_rst), .cycle (d_cyc), .running (d_run)
  );

  clock_gen #(.HALF_PERIOD(5), .RESET_CYCLES(3)) u_hp5 (
    .clock (h_clk), .reset (h_rst), .cycle (h_cyc), .running (h_run)
  );

  clock_gen #(.RESET_CYCLES(0)) u_rc0 (
    .clock (z_clk), .reset (z_rst), .cycle (z_cyc), .running (z_run)
  );

  clock_gen #(.CYCLE_W(2), .RESET_CYCLES(1)) u_w2 (
    .clock (n_clk), .reset (n_rst), .cycle (n_cyc), .running (n_run)
  );

  clock_gen #(.RESET_CYCLES(0), .MAX_CYCLES(c_wd_max)) u_wd (
    .clock (w_clk), .reset (w_rst), .cycle (w_cyc), .running (w_run)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $realtime, got, exp);
    end
  endtask

  // Reference model, sampled at time t + 0.5 (never on an edge).
  function automatic logic m_clock(input int t, input int hp);
    return ((t / hp) % 2) == 0;
  endfunction

  function automatic logic m_reset(input int t, input int hp, input int rc);
    return (rc > 0) && (t < 2 * hp * rc + hp);
  endfunction

  function automatic logic [31:0] m_cycle(input int t, input int hp, input int rc, input int w);
    longint n;
    n = longint'(t / (2 * hp)) - longint'(rc);
    if (n < 0) n = 0;
    return 32'(n % (longint'(1) << w));
  endfunction

  task automatic check_all(input int t);
    chk("def_clock",   32'(d_clk), 32'(m_clock(t, 1)));
    chk("def_reset",   32'(d_rst), 32'(m_reset(t, 1, 2)));
    chk("def_cycle",   d_cyc,      m_cycle(t, 1, 2, 32));
    chk("def_running", 32'(d_run), 32'd1);
    chk("hp5_clock",   32'(h_clk), 32'(m_clock(t, 5)));
    chk("hp5_reset",   32'(h_rst), 32'(m_reset(t, 5, 3)));
    chk("hp5_cycle",   h_cyc,      m_cycle(t, 5, 3, 32));
    chk("rc0_reset",   32'(z_rst), 32'(m_reset(t, 1, 0)));
    chk("rc0_cycle",   z_cyc,      m_cycle(t, 1, 0, 32));
    chk("w2_reset",    32'(n_rst), 32'(m_reset(t, 1, 1)));
    chk("w2_cycle",    32'(n_cyc), m_cycle(t, 1, 1, 2));
    chk("wd_cycle",    w_cyc,      m_cycle(t, 1, 0, 32));
    chk("wd_running",  32'(w_run), 32'd1);
  endtask

  initial begin
    int t;
    int d;
    t = 0;
    #0.5;
    while (t < 112) begin
      check_all(t);
      d = int'($urandom_range(1, 3));
      #(d);
      t += d;
    end
    // The watchdog instance ends the run; reaching here means it never fired.
    #100;
    chk("wd_timeout", 32'd0, 32'd1);
    $finish;
  end

  final begin
    chk("wd_end_time", 32'($time), 32'(2 * c_wd_max));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  end

endmodule : tb_clock_gen
`default_nettype wire
